// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC job arbiter: command field layout,
// engine mode codes, response tags and the arbiter FSM state encoding.
package cordic_pkg;

    localparam int CMD_W       = 48;
    localparam int OPND_W      = 32;
    localparam int TAG_W       = 16;
    localparam int MODE_W      = 8;
    localparam int CMD_MODE_HI = 39;
    localparam int CMD_MODE_LO = 32;

    localparam logic [MODE_W-1:0] MODE_SIN   = 8'd1;
    localparam logic [MODE_W-1:0] MODE_COS   = 8'd2;
    localparam logic [MODE_W-1:0] MODE_TAN   = 8'd3;
    localparam logic [MODE_W-1:0] MODE_SINH  = 8'd4;
    localparam logic [MODE_W-1:0] MODE_COSH  = 8'd5;
    localparam logic [MODE_W-1:0] MODE_TANH  = 8'd6;
    localparam logic [MODE_W-1:0] MODE_SQRT  = 8'd7;
    localparam logic [MODE_W-1:0] MODE_ATAN  = 8'd8;
    localparam logic [MODE_W-1:0] MODE_LN    = 8'd9;
    localparam logic [MODE_W-1:0] MODE_ASIN  = 8'd10;
    localparam logic [MODE_W-1:0] MODE_ACOS  = 8'd11;
    localparam logic [MODE_W-1:0] MODE_FIRST = MODE_SIN;
    localparam logic [MODE_W-1:0] MODE_LAST  = MODE_ACOS;

    // Tags the arbiter itself writes into the upper response field.
    localparam logic [TAG_W-1:0] TAG_REJECT  = 16'hFFFF;
    localparam logic [TAG_W-1:0] TAG_TIMEOUT = 16'hFFFE;

    // Tags the engine uses for ordinary results.
    localparam logic [TAG_W-1:0] TAG_RES_FIRST = 16'h000A;
    localparam logic [TAG_W-1:0] TAG_RES_LAST  = 16'h000F;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND0    = 3'd1,
        ST_GET1     = 3'd2,
        ST_SEND1    = 3'd3,
        ST_WAIT_RSP = 3'd4,
        ST_REJECT   = 3'd5
    } arb_state_e;

    function automatic logic [MODE_W-1:0] cmd_mode(input logic [CMD_W-1:0] word);
        return word[CMD_MODE_HI:CMD_MODE_LO];
    endfunction

    function automatic logic mode_is_valid(input logic [MODE_W-1:0] mode);
        return (mode >= MODE_FIRST) && (mode <= MODE_LAST);
    endfunction

    function automatic logic mode_is_two_beat(input logic [MODE_W-1:0] mode);
        return mode == MODE_ATAN;
    endfunction

endpackage

// File: rtl/cordic_job_arbiter_if.sv
// Bundle of requester-side and engine-side signals of the CORDIC job arbiter.
// Handshakes: a beat moves on a cycle where valid and ready are both high;
// valid never waits on ready, and data stays stable while valid && !ready.
interface cordic_job_arbiter_if
    import cordic_pkg::*;
#(
    parameter int N_REQ = 4
) ();

    logic [N_REQ-1:0]       req_valid;
    logic [CMD_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;

    logic                   eng_valid;
    logic [CMD_W-1:0]       eng_data;
    logic                   eng_ready;
    logic                   eng_abort;
    logic                   eng_rsp_valid;
    logic [CMD_W-1:0]       eng_rsp_data;

    logic [N_REQ-1:0]       rsp_valid;
    logic [CMD_W-1:0]       rsp_data;
    logic                   busy;
    logic                   err_timeout;

    // The arbiter side.
    modport slave (
        input  req_valid, req_data, eng_ready, eng_rsp_valid, eng_rsp_data,
        output req_ready, eng_valid, eng_data, eng_abort,
               rsp_valid, rsp_data, busy, err_timeout
    );

    // The requesters and engine around the arbiter.
    modport master (
        output req_valid, req_data, eng_ready, eng_rsp_valid, eng_rsp_data,
        input  req_ready, eng_valid, eng_data, eng_abort,
               rsp_valid, rsp_data, busy, err_timeout
    );

endinterface

// File: rtl/cordic_rr_arbiter.sv
// Combinational round-robin picker: the requester just after last_grant has
// highest priority, wrapping modulo N_REQ.
module cordic_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     grant_valid
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // One spare bit on the sum so last_grant + N_REQ cannot overflow before the wrap.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        cand        = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            sum = {1'b0, last_grant} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_job_arbiter.sv
// Shares one CORDIC engine between N_REQ requesters: round-robin grant, one or
// two command beats forwarded, result routed back, with a response watchdog.
module cordic_job_arbiter
    import cordic_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    cordic_job_arbiter_if.slave  bus,
    output arb_state_e           dbg_state
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    arb_state_e       state_q, state_d;
    logic [CMD_W-1:0] cmd0_q, cmd0_d;
    logic [CMD_W-1:0] cmd1_q, cmd1_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [CMD_W-1:0] rsp_data_q, rsp_data_d;
    logic             abort_q, abort_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic [N_REQ-1:0] req_ready;
    logic [N_REQ-1:0] owner_oh;
    logic [CMD_W-1:0] win_word;
    logic [CMD_W-1:0] own_word;
    logic             wd_expired;
    logic             fire_timeout;

    cordic_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req         (bus.req_valid),
        .last_grant  (last_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign win_word   = bus.req_data[CMD_W*int'(arb_idx) +: CMD_W];
    assign own_word   = bus.req_data[CMD_W*int'(gnt_q) +: CMD_W];
    assign owner_oh   = N_REQ'(1) << gnt_q;
    assign wd_expired = (wd_q == CNT_W'(TIMEOUT-1));

    // req_ready is held low during reset so no beat is taken by a job that the
    // reset is about to discard.
    always_comb begin
        state_d      = state_q;
        cmd0_d       = cmd0_q;
        cmd1_d       = cmd1_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        wd_d         = wd_q;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        abort_d      = 1'b0;
        err_d        = 1'b0;
        req_ready    = '0;
        fire_timeout = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid && !reset) begin
                    req_ready = arb_grant;
                    cmd0_d    = win_word;
                    gnt_d     = arb_idx;
                    last_d    = arb_idx;
                    if (mode_is_valid(cmd_mode(win_word))) begin
                        state_d = ST_SEND0;
                    end else begin
                        state_d     = ST_REJECT;
                        rsp_valid_d = arb_grant;
                        rsp_data_d  = {TAG_REJECT, 32'h0};
                    end
                end
            end
            ST_SEND0: begin
                if (bus.eng_ready) begin
                    wd_d    = '0;
                    state_d = mode_is_two_beat(cmd_mode(cmd0_q)) ? ST_GET1 : ST_WAIT_RSP;
                end
            end
            ST_GET1: begin
                // Only the owner of the arctan job may supply its second beat.
                req_ready = reset ? '0 : owner_oh;
                if (bus.req_valid[gnt_q] && !reset) begin
                    cmd1_d  = own_word;
                    state_d = ST_SEND1;
                end else if (wd_expired) begin
                    fire_timeout = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_SEND1: begin
                if (bus.eng_ready) begin
                    wd_d    = '0;
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (bus.eng_rsp_valid) begin
                    rsp_valid_d = owner_oh;
                    rsp_data_d  = bus.eng_rsp_data;
                    state_d     = ST_IDLE;
                end else if (wd_expired) begin
                    fire_timeout = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_REJECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fire_timeout) begin
            abort_d     = 1'b1;
            err_d       = 1'b1;
            rsp_valid_d = owner_oh;
            rsp_data_d  = {TAG_TIMEOUT, 32'h0};
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd0_q      <= '0;
            cmd1_q      <= '0;
            gnt_q       <= '0;
            last_q      <= IDX_W'(N_REQ-1);
            wd_q        <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            abort_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd0_q      <= cmd0_d;
            cmd1_q      <= cmd1_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            wd_q        <= wd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            abort_q     <= abort_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.eng_valid   = (state_q == ST_SEND0) || (state_q == ST_SEND1);
    assign bus.eng_data    = (state_q == ST_SEND0) ? cmd0_q :
                             (state_q == ST_SEND1) ? cmd1_q : '0;
    assign bus.eng_abort   = abort_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.err_timeout = err_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_cordic_job_arbiter.sv
// Directed bench for cordic_job_arbiter: one default instance for the main
// traffic and a second one with a 16-cycle watchdog for the abort path.
module tb_cordic_job_arbiter;
    import cordic_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    arb_state_e state;
    arb_state_e wstate;
    logic [3:0] oh;

    cordic_job_arbiter_if #(.N_REQ(N)) bus ();
    cordic_job_arbiter_if #(.N_REQ(N)) wbus ();

    cordic_job_arbiter #(.N_REQ(N), .TIMEOUT(1024)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (state)
    );

    cordic_job_arbiter #(.N_REQ(N), .TIMEOUT(16)) wdut (
        .clk       (clk),
        .reset     (reset),
        .bus       (wbus),
        .dbg_state (wstate)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] cmd(input logic [7:0] mode, input logic [31:0] opnd);
        return {8'h00, mode, opnd};
    endfunction

    task automatic drive_req(input int i, input logic v, input logic [47:0] d);
        bus.req_valid[i]        = v;
        bus.req_data[48*i +: 48] = d;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_req_ready"}, bus.req_ready, 4'b0000);
        check({pfx, "_eng_valid"}, bus.eng_valid, 1'b0);
        check({pfx, "_eng_data"}, bus.eng_data, 48'h0);
        check({pfx, "_eng_abort"}, bus.eng_abort, 1'b0);
        check({pfx, "_rsp_valid"}, bus.rsp_valid, 4'b0000);
        check({pfx, "_rsp_data"}, bus.rsp_data, 48'h0);
        check({pfx, "_busy"}, bus.busy, 1'b0);
        check({pfx, "_err_timeout"}, bus.err_timeout, 1'b0);
        check({pfx, "_state"}, state, ST_IDLE);
    endtask

    initial begin
        #500000;
        $display("FAIL tb_time_limit observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        bus.req_valid      = '0;
        bus.req_data       = '0;
        bus.eng_ready      = 1'b0;
        bus.eng_rsp_valid  = 1'b0;
        bus.eng_rsp_data   = '0;
        wbus.req_valid     = '0;
        wbus.req_data      = '0;
        wbus.eng_ready     = 1'b0;
        wbus.eng_rsp_valid = 1'b0;
        wbus.eng_rsp_data  = '0;

        // Reset values
        tick(3);
        reset = 1'b0;
        #1;
        check_all_zero("reset");

        // Single sin request, engine answers 20 cycles after acceptance
        drive_req(0, 1'b1, cmd(MODE_SIN, 32'h0000_4000));
        #1;
        check("sin_ready", bus.req_ready, 4'b0001);
        tick();
        drive_req(0, 1'b0, 48'h0);
        #1;
        check("sin_state_send0", state, ST_SEND0);
        check("sin_eng_valid", bus.eng_valid, 1'b1);
        check("sin_eng_data", bus.eng_data, 48'h0001_0000_4000);
        check("sin_busy", bus.busy, 1'b1);
        bus.eng_ready = 1'b1;
        tick();
        bus.eng_ready = 1'b0;
        check("sin_state_wait", state, ST_WAIT_RSP);
        check("sin_eng_valid_off", bus.eng_valid, 1'b0);
        tick(18);
        check("sin_no_early_rsp", bus.rsp_valid, 4'b0000);
        bus.eng_rsp_valid = 1'b1;
        bus.eng_rsp_data  = {16'h000A, 32'h0000_1234};
        tick();
        bus.eng_rsp_valid = 1'b0;
        check("sin_rsp_valid", bus.rsp_valid, 4'b0001);
        check("sin_rsp_data", bus.rsp_data, 48'h000A_0000_1234);
        check("sin_state_idle", state, ST_IDLE);
        tick();
        check("sin_rsp_pulse_end", bus.rsp_valid, 4'b0000);
        check("sin_busy_low", bus.busy, 1'b0);

        // Fairness: all four hold mode 7, engine answers in 3 cycles
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            drive_req(i, 1'b1, cmd(MODE_SQRT, 32'(i)));
        end
        #1;
        for (int k = 0; k < 12; k++) begin
            oh = 4'b0001 << (k % 4);
            check($sformatf("fair%0d_ready", k), bus.req_ready, oh);
            tick();
            check($sformatf("fair%0d_eng_data", k), bus.eng_data, cmd(MODE_SQRT, 32'(k % 4)));
            bus.eng_ready = 1'b1;
            tick();
            bus.eng_ready = 1'b0;
            tick(2);
            bus.eng_rsp_valid = 1'b1;
            bus.eng_rsp_data  = {16'h000A, 32'(k)};
            tick();
            bus.eng_rsp_valid = 1'b0;
            #1;
            check($sformatf("fair%0d_rsp_valid", k), bus.rsp_valid, oh);
            check($sformatf("fair%0d_rsp_data", k), bus.rsp_data, {16'h000A, 32'(k)});
        end
        bus.req_valid = '0;
        tick();
        check("fair_idle", state, ST_IDLE);

        // Invalid modes 0 and 12 from requester 1
        drive_req(1, 1'b1, cmd(8'd0, 32'h55));
        #1;
        check("rej0_ready", bus.req_ready, 4'b0010);
        tick();
        check("rej0_state", state, ST_REJECT);
        check("rej0_rsp_valid", bus.rsp_valid, 4'b0010);
        check("rej0_rsp_data", bus.rsp_data, 48'hFFFF_0000_0000);
        check("rej0_eng_valid", bus.eng_valid, 1'b0);
        drive_req(1, 1'b1, cmd(8'd12, 32'h66));
        #1;
        check("rej_ready_in_reject", bus.req_ready, 4'b0000);
        tick();
        check("rej12_idle", state, ST_IDLE);
        check("rej12_ready", bus.req_ready, 4'b0010);
        check("rej_gap_rsp", bus.rsp_valid, 4'b0000);
        tick();
        drive_req(1, 1'b0, 48'h0);
        #1;
        check("rej12_rsp_valid", bus.rsp_valid, 4'b0010);
        check("rej12_rsp_data", bus.rsp_data, 48'hFFFF_0000_0000);
        check("rej12_eng_valid", bus.eng_valid, 1'b0);
        tick();
        check("rej_done_idle", state, ST_IDLE);

        // Arctan from requester 2 while requester 0 waits
        drive_req(0, 1'b1, cmd(MODE_SIN, 32'h0000_AAAA));
        drive_req(2, 1'b1, cmd(MODE_ATAN, 32'h0000_0100));
        #1;
        check("atan_ready", bus.req_ready, 4'b0100);
        tick();
        drive_req(2, 1'b0, 48'h0);
        #1;
        check("atan_x_valid", bus.eng_valid, 1'b1);
        check("atan_x_data", bus.eng_data, 48'h0008_0000_0100);
        check("atan_send0_lock", bus.req_ready, 4'b0000);
        bus.eng_ready = 1'b1;
        tick();
        bus.eng_ready = 1'b0;
        #1;
        check("atan_state_get1", state, ST_GET1);
        check("atan_get1_ready", bus.req_ready, 4'b0100);
        check("atan_get1_eng_valid", bus.eng_valid, 1'b0);
        for (int d = 0; d < 5; d++) begin
            tick();
            check($sformatf("atan_lock%0d", d), bus.req_ready, 4'b0100);
        end
        drive_req(2, 1'b1, 48'h003C_0000_0200);
        #1;
        check("atan_y_ready", bus.req_ready, 4'b0100);
        tick();
        drive_req(2, 1'b0, 48'h0);
        #1;
        check("atan_state_send1", state, ST_SEND1);
        check("atan_y_valid", bus.eng_valid, 1'b1);
        check("atan_y_data", bus.eng_data, 48'h003C_0000_0200);
        check("atan_send1_lock", bus.req_ready, 4'b0000);
        bus.eng_ready = 1'b1;
        tick();
        bus.eng_ready = 1'b0;
        check("atan_state_wait", state, ST_WAIT_RSP);
        check("atan_wait_lock", bus.req_ready, 4'b0000);
        bus.eng_rsp_valid = 1'b1;
        bus.eng_rsp_data  = {16'h000B, 32'h0000_4567};
        tick();
        bus.eng_rsp_valid = 1'b0;
        #1;
        check("atan_rsp_valid", bus.rsp_valid, 4'b0100);
        check("atan_rsp_data", bus.rsp_data, 48'h000B_0000_4567);
        check("atan_req0_released", bus.req_ready, 4'b0001);

        // Reset while requester 0's job sits in WAIT_RSP
        tick();
        check("rst_job_data", bus.eng_data, 48'h0001_0000_AAAA);
        bus.eng_ready = 1'b1;
        tick();
        bus.eng_ready = 1'b0;
        check("rst_state_wait", state, ST_WAIT_RSP);
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            drive_req(i, 1'b1, cmd(MODE_COS, 32'(i)));
        end
        tick();
        check_all_zero("rst_mid");
        reset = 1'b0;
        #1;
        check("rst_first_grant", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        tick();
        check("rst_no_rsp", bus.rsp_valid, 4'b0000);
        check("rst_no_abort", bus.eng_abort, 1'b0);

        // Watchdog with TIMEOUT=16 and a silent engine
        wbus.req_valid[0]     = 1'b1;
        wbus.req_data[47:0]   = cmd(MODE_COS, 32'h10);
        #1;
        check("wd_ready", wbus.req_ready, 4'b0001);
        tick();
        wbus.req_valid = '0;
        #1;
        check("wd_eng_valid", wbus.eng_valid, 1'b1);
        wbus.eng_ready = 1'b1;
        tick();
        wbus.eng_ready = 1'b0;
        check("wd_state_wait", wstate, ST_WAIT_RSP);
        tick(14);
        check("wd_no_abort_14", wbus.eng_abort, 1'b0);
        tick();
        check("wd_still_wait_15", wstate, ST_WAIT_RSP);
        check("wd_no_abort_15", wbus.eng_abort, 1'b0);
        tick();
        check("wd_abort", wbus.eng_abort, 1'b1);
        check("wd_err", wbus.err_timeout, 1'b1);
        check("wd_rsp_valid", wbus.rsp_valid, 4'b0001);
        check("wd_rsp_data", wbus.rsp_data, 48'hFFFE_0000_0000);
        check("wd_state_idle", wstate, ST_IDLE);
        check("wd_busy", wbus.busy, 1'b0);
        tick();
        check("wd_abort_pulse_end", wbus.eng_abort, 1'b0);
        check("wd_err_pulse_end", wbus.err_timeout, 1'b0);
        check("wd_rsp_pulse_end", wbus.rsp_valid, 4'b0000);
        wbus.eng_rsp_valid = 1'b1;
        wbus.eng_rsp_data  = {16'h000C, 32'h99};
        tick();
        wbus.eng_rsp_valid = 1'b0;
        check("wd_late_dropped", wbus.rsp_valid, 4'b0000);
        check("wd_late_state", wstate, ST_IDLE);
        tick();
        check("wd_late_dropped2", wbus.rsp_valid, 4'b0000);
        check("wd_late_no_abort", wbus.eng_abort, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
